// File: rtl/cache_pkg.sv
// cache_pkg: shared types and address helpers for the set-associative cache.
//   cache_state_e : controller states (IDLE, FILL, WRITE)
//   cache_mode_e  : request direction, read = 0, write = 1
//   idx_of/tag_of : set index and tag extraction from a request address
//   way_bits      : width of a way number (at least 1 bit)
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_e;

    // WRITE is already taken by the state enum in this scope, so the mode
    // literals carry a prefix.
    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } cache_mode_e;

    function automatic logic [31:0] idx_of(input logic [63:0] a, input int idx_w);
        return 32'(a & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic logic [31:0] tag_of(input logic [63:0] a, input int idx_w,
                                           input int tag_w);
        return 32'((a >> idx_w) & ((64'd1 << tag_w) - 64'd1));
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set age counters used for victim selection.
//   clk, rst     : clock, asynchronous active-low reset (clears all ages)
//   set_idx      : set being looked up / updated
//   way          : way being accessed when upd is high
//   upd          : strobe, makes 'way' the most recently used in set_idx
//   set_valid    : valid bits of the ways in set_idx
//   lru_way      : oldest way of set_idx (lowest number on a tie)
//   inv_way      : lowest-numbered invalid way of set_idx
//   inv_any      : set_idx has at least one invalid way
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int IDX_W = 6,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAY_W-1:0] way,
    input  logic             upd,
    input  logic [WAYS-1:0]  set_valid,
    output logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] inv_way,
    output logic             inv_any
);

    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    if (WAYS > 1) begin : g_lru
        localparam int AGE_W = $clog2(WAYS);

        logic [AGE_W-1:0] age [SETS][WAYS];
        logic [AGE_W-1:0] old_age;
        logic [AGE_W-1:0] best;

        always_comb begin
            old_age = age[set_idx][way];
            best    = '0;
            lru_way = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age[set_idx][w] > best) begin
                    best    = age[set_idx][w];
                    lru_way = WAY_W'(w);
                end
            end
        end

        // Other ways at or below the accessed way's old age get one step
        // older. Including equal ages lets a freshly reset set (all ages 0)
        // settle into a strict ordering; once ages are distinct this is the
        // usual "ages younger than the old age advance" rule.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age[s][w] <= '0;
            end else if (upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way)
                        age[set_idx][w] <= '0;
                    else if (age[set_idx][w] <= old_age && age[set_idx][w] != '1)
                        age[set_idx][w] <= age[set_idx][w] + 1'b1;
                end
            end
        end
    end else begin : g_no_lru
        logic unused_lru;
        assign unused_lru = ^{clk, rst, set_idx, way, upd};
        assign lru_way    = '0;
    end

endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: set-associative, write-through, no-write-allocate cache with
// LRU replacement and req/ack handshakes towards the backing memory.
//   clk, rst                   : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   mode, address, data        : request direction, address, write data
//   out, out_valid             : read data (held) and its one-cycle strobe
//   mem_rd_req/addr/ack/data   : line fill handshake
//   mem_wr_req/addr/data/ack   : write-through handshake
//   hit_count, miss_count      : saturating counters, only when the macro
//                                CACHE_STATS_EN is defined
module cache_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = way_bits(WAYS);

    cache_state_e state;

    logic [DATA_W-1:0] cache       [SETS][WAYS];
    logic              valid_array [SETS][WAYS];
    logic [TAG_W-1:0]  tag_array   [SETS][WAYS];

    logic [ADDR_W-1:0] addr_sel;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAYS-1:0]   set_valid;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  inv_way;
    logic              inv_any;
    logic [WAY_W-1:0]  victim;
    logic              accept;
    logic              is_wr;
    logic              fill_done;
    logic              lru_upd;
    logic [WAY_W-1:0]  lru_sel;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign is_wr     = (cache_mode_e'(mode) == MODE_WRITE);
    assign fill_done = (state == FILL) & mem_rd_ack;

    // During a fill, mem_rd_addr still holds the missed address, so it
    // doubles as the latched lookup address.
    assign addr_sel = (state == FILL) ? mem_rd_addr : address;
    assign index    = IDX_W'(idx_of(64'(addr_sel), IDX_W));
    assign tag      = TAG_W'(tag_of(64'(addr_sel), IDX_W, TAG_W));

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        set_valid = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            set_valid[w] = valid_array[index][w];
            if (valid_array[index][w] && tag_array[index][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign victim  = inv_any ? inv_way : lru_way;
    assign lru_upd = (accept & hit) | fill_done;
    assign lru_sel = fill_done ? victim : hit_way;

    cache_lru #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (index),
        .way       (lru_sel),
        .upd       (lru_upd),
        .set_valid (set_valid),
        .lru_way   (lru_way),
        .inv_way   (inv_way),
        .inv_any   (inv_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            out         <= '0;
            out_valid   <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    cache[s][w]       <= '0;
                    valid_array[s][w] <= 1'b0;
                    tag_array[s][w]   <= '0;
                end
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_wr) begin
                            // No write-allocate: only a hit touches the line.
                            if (hit)
                                cache[index][hit_way] <= data;
                            mem_wr_req  <= 1'b1;
                            mem_wr_addr <= address;
                            mem_wr_data <= data;
                            state       <= WRITE;
                        end else if (hit) begin
                            out       <= cache[index][hit_way];
                            out_valid <= 1'b1;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= address;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_rd_ack) begin
                        cache[index][victim]       <= mem_rd_data;
                        valid_array[index][victim] <= 1'b1;
                        tag_array[index][victim]   <= tag;
                        out                        <= mem_rd_data;
                        out_valid                  <= 1'b1;
                        mem_rd_req                 <= 1'b0;
                        state                      <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF)
                    hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF)
                    miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed self-checking bench for cache_assoc
// (SETS=64, WAYS=2, TAG_W=6). Each scenario task drives its own stimulus
// and compares against hand-computed values. Stats checks are compiled
// only when CACHE_STATS_EN is defined.
module tb_cache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data = '0;
    logic        req_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cache_assoc #(
        .ADDR_W (32),
        .DATA_W (32),
        .SETS   (64),
        .WAYS   (2),
        .TAG_W  (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mode        (mode),
        .address     (address),
        .data        (data),
        .out         (out),
        .out_valid   (out_valid),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) step;
        rst = 1'b1;
    endtask

    // Issues a read. On a miss (mem_rd_req seen the cycle after acceptance)
    // waits dly request cycles, then acks with fill. Returns what the DUT
    // showed; on a ready timeout every result is X so the checks fail.
    task automatic rd_txn(input logic [31:0] a, input int dly, input logic [31:0] fill,
                          output logic miss, output logic [31:0] raddr,
                          output logic [31:0] o, output logic ov);
        int n = 0;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        if (!req_ready) begin
            miss = 1'bx; raddr = 'x; o = 'x; ov = 1'bx;
            return;
        end
        req_valid = 1'b1; mode = 1'b0; address = a;
        step;
        req_valid = 1'b0;
        miss  = mem_rd_req;
        raddr = mem_rd_addr;
        if (miss) begin
            repeat (dly) step;
            mem_rd_ack = 1'b1; mem_rd_data = fill;
            step;
            mem_rd_ack = 1'b0; mem_rd_data = '0;
        end
        o  = out;
        ov = out_valid;
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input int dly,
                          output logic wreq, output logic [31:0] wa, output logic [31:0] wd,
                          output logic rdy_mid, output logic rdy_end, output logic wreq_end);
        int n = 0;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        if (!req_ready) begin
            wreq = 1'bx; wa = 'x; wd = 'x; rdy_mid = 1'bx; rdy_end = 1'bx; wreq_end = 1'bx;
            return;
        end
        req_valid = 1'b1; mode = 1'b1; address = a; data = d;
        step;
        req_valid = 1'b0; mode = 1'b0;
        wreq = mem_wr_req; wa = mem_wr_addr; wd = mem_wr_data; rdy_mid = req_ready;
        repeat (dly) step;
        mem_wr_ack = 1'b1;
        step;
        mem_wr_ack = 1'b0;
        rdy_end = req_ready; wreq_end = mem_wr_req;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) step;
        n_chk++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_hold_req: rd=%b wr=%b want 0/0", mem_rd_req, mem_wr_req); end
        rst = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_chk++; if (out !== 32'h0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out: out=%h vld=%b want 0/0", out, out_valid); end
        n_chk++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: rd=%b wr=%b want 0/0", mem_rd_req, mem_wr_req); end
        n_chk++; if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== 96'h0) begin n_fail++; $display("FAIL rst_bus: %h %h %h want 0", mem_rd_addr, mem_wr_addr, mem_wr_data); end
    endtask

    task automatic test_read_miss_hit;
        logic m; logic [31:0] ra, o; logic ov;
        rd_txn(32'h45, 3, 32'hDEAD_BEEF, m, ra, o, ov);
        n_chk++; if (m !== 1'b1) begin n_fail++; $display("FAIL rmh_miss: got %b want 1", m); end
        n_chk++; if (ra !== 32'h45) begin n_fail++; $display("FAIL rmh_rdaddr: got %h want 00000045", ra); end
        n_chk++; if (o !== 32'hDEAD_BEEF || ov !== 1'b1) begin n_fail++; $display("FAIL rmh_fill_out: out=%h vld=%b want deadbeef/1", o, ov); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmh_ready: got %b want 1", req_ready); end
        step;
        n_chk++; if (out_valid !== 1'b0 || out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rmh_pulse: out=%h vld=%b want deadbeef/0", out, out_valid); end
        rd_txn(32'h45, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0) begin n_fail++; $display("FAIL rmh_hit: miss=%b want 0", m); end
        n_chk++; if (o !== 32'hDEAD_BEEF || ov !== 1'b1) begin n_fail++; $display("FAIL rmh_hit_out: out=%h vld=%b want deadbeef/1", o, ov); end
`ifdef CACHE_STATS_EN
        n_chk++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin n_fail++; $display("FAIL rmh_stats: hit=%0d miss=%0d want 1/1", hit_count, miss_count); end
`endif
    endtask

    task automatic test_lru_evict;
        logic m; logic [31:0] ra, o; logic ov;
        do_reset;
        rd_txn(32'h45, 0, 32'hA1A1_A1A1, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || o !== 32'hA1A1_A1A1 || ov !== 1'b1) begin n_fail++; $display("FAIL lru_fill1: miss=%b out=%h vld=%b want 1/a1a1a1a1/1", m, o, ov); end
        rd_txn(32'h85, 1, 32'hA2A2_A2A2, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || o !== 32'hA2A2_A2A2) begin n_fail++; $display("FAIL lru_fill2: miss=%b out=%h want 1/a2a2a2a2", m, o); end
        rd_txn(32'hC5, 0, 32'hA3A3_A3A3, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || ra !== 32'hC5 || o !== 32'hA3A3_A3A3) begin n_fail++; $display("FAIL lru_fill3: miss=%b addr=%h out=%h want 1/c5/a3a3a3a3", m, ra, o); end
        rd_txn(32'h85, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'hA2A2_A2A2 || ov !== 1'b1) begin n_fail++; $display("FAIL lru_keep85: miss=%b out=%h vld=%b want 0/a2a2a2a2/1", m, o, ov); end
        rd_txn(32'h45, 0, 32'hB1B1_B1B1, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || o !== 32'hB1B1_B1B1) begin n_fail++; $display("FAIL lru_evicted45: miss=%b out=%h want 1/b1b1b1b1", m, o); end
        rd_txn(32'h85, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'hA2A2_A2A2) begin n_fail++; $display("FAIL lru_still85: miss=%b out=%h want 0/a2a2a2a2", m, o); end
        rd_txn(32'hC5, 0, 32'hB3B3_B3B3, m, ra, o, ov);
        n_chk++; if (m !== 1'b1) begin n_fail++; $display("FAIL lru_evictedC5: miss=%b want 1", m); end
    endtask

    task automatic test_write;
        logic m; logic [31:0] ra, o; logic ov;
        logic wq, rm, re, we; logic [31:0] wa, wd;
        do_reset;
        rd_txn(32'h45, 0, 32'h1111_1111, m, ra, o, ov);
        wr_txn(32'h45, 32'h1234_5678, 2, wq, wa, wd, rm, re, we);
        n_chk++; if (wq !== 1'b1 || wa !== 32'h45 || wd !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_hit_bus: req=%b addr=%h data=%h want 1/45/12345678", wq, wa, wd); end
        n_chk++; if (rm !== 1'b0 || re !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL wr_hit_hs: rdy_mid=%b rdy_end=%b req_end=%b want 0/1/0", rm, re, we); end
        n_chk++; if (out !== 32'h1111_1111 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wr_out_held: out=%h vld=%b want 11111111/0", out, out_valid); end
        rd_txn(32'h45, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_hit_read: miss=%b out=%h want 0/12345678", m, o); end
        wr_txn(32'h105, 32'hCAFE_F00D, 0, wq, wa, wd, rm, re, we);
        n_chk++; if (wq !== 1'b1 || wa !== 32'h105 || wd !== 32'hCAFE_F00D || re !== 1'b1) begin n_fail++; $display("FAIL wr_miss_bus: req=%b addr=%h data=%h rdy=%b want 1/105/cafef00d/1", wq, wa, wd, re); end
        rd_txn(32'h105, 1, 32'h0BAD_F00D, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || ra !== 32'h105 || o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wr_miss_noalloc: miss=%b addr=%h out=%h want 1/105/0badf00d", m, ra, o); end
        rd_txn(32'h1045, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_upper_bits: miss=%b out=%h want 0/12345678", m, o); end
    endtask

    task automatic test_back_to_back;
        logic m; logic [31:0] ra, o; logic ov;
        req_valid = 1'b1; mode = 1'b0; address = 32'h45;
        step;
        n_chk++; if (out !== 32'h1234_5678 || out_valid !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first: out=%h vld=%b rdy=%b want 12345678/1/1", out, out_valid, req_ready); end
        address = 32'h105;
        step;
        req_valid = 1'b0;
        n_chk++; if (out !== 32'h0BAD_F00D || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: out=%h vld=%b want 0badf00d/1", out, out_valid); end
        step;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: vld=%b want 0", out_valid); end
        rd_txn(32'h145, 0, 32'h5555_5555, m, ra, o, ov);
        rd_txn(32'h145, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'h5555_5555 || ov !== 1'b1) begin n_fail++; $display("FAIL b2b_after_fill: miss=%b out=%h vld=%b want 0/55555555/1", m, o, ov); end
        rd_txn(32'h105, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (m !== 1'b0 || o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_mru_kept: miss=%b out=%h want 0/0badf00d", m, o); end
    endtask

    task automatic test_stray_ack;
        mem_rd_ack = 1'b1; mem_rd_data = 32'hFFFF_FFFF; mem_wr_ack = 1'b1;
        repeat (2) step;
        mem_rd_ack = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
        n_chk++; if (out !== 32'h0BAD_F00D || out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_out: out=%h vld=%b want 0badf00d/0", out, out_valid); end
        n_chk++; if (req_ready !== 1'b1 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL stray_state: rdy=%b rd=%b wr=%b want 1/0/0", req_ready, mem_rd_req, mem_wr_req); end
    endtask

    task automatic test_reset_mid_fill;
        logic m; logic [31:0] ra, o; logic ov;
        req_valid = 1'b1; mode = 1'b0; address = 32'hC7;
        step;
        req_valid = 1'b0;
        n_chk++; if (mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL rmf_req: got %b want 1", mem_rd_req); end
        repeat (2) step;
        rst = 1'b0;
        #1;
        n_chk++; if (mem_rd_req !== 1'b0 || mem_rd_addr !== 32'h0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_drop: req=%b addr=%h rdy=%b want 0/0/1", mem_rd_req, mem_rd_addr, req_ready); end
        n_chk++; if (out !== 32'h0) begin n_fail++; $display("FAIL rmf_out: got %h want 0", out); end
        repeat (2) step;
        rst = 1'b1;
        rd_txn(32'hC7, 0, 32'h7777_7777, m, ra, o, ov);
        n_chk++; if (m !== 1'b1 || ra !== 32'hC7 || o !== 32'h7777_7777) begin n_fail++; $display("FAIL rmf_remiss: miss=%b addr=%h out=%h want 1/c7/77777777", m, ra, o); end
        rd_txn(32'h145, 0, 32'h6666_6666, m, ra, o, ov);
        n_chk++; if (m !== 1'b1) begin n_fail++; $display("FAIL rmf_cleared: miss=%b want 1", m); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats;
        logic m; logic [31:0] ra, o; logic ov;
        logic wq, rm, re, we; logic [31:0] wa, wd;
        do_reset;
        n_chk++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL st_reset: hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
        rd_txn(32'h45, 0, 32'h1, m, ra, o, ov);
        rd_txn(32'h45, 0, 32'h0, m, ra, o, ov);
        wr_txn(32'h45, 32'h2, 0, wq, wa, wd, rm, re, we);
        wr_txn(32'h205, 32'h3, 0, wq, wa, wd, rm, re, we);
        n_chk++; if (hit_count !== 32'd2 || miss_count !== 32'd2) begin n_fail++; $display("FAIL st_counts: hit=%0d miss=%0d want 2/2", hit_count, miss_count); end
        force dut.hit_count = 32'hFFFF_FFFF;
        step;
        release dut.hit_count;
        rd_txn(32'h45, 0, 32'h0, m, ra, o, ov);
        n_chk++; if (hit_count !== 32'hFFFF_FFFF || miss_count !== 32'd2) begin n_fail++; $display("FAIL st_saturate: hit=%h miss=%0d want ffffffff/2", hit_count, miss_count); end
    endtask
`endif

    initial begin
        test_reset;
        test_read_miss_hit;
        test_lru_evict;
        test_write;
        test_back_to_back;
        test_stray_ack;
        test_reset_mid_fill;
`ifdef CACHE_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised set-associative, write-through, no-write-allocate cache between a single requester and a handshaked backing memory. It generalises the direct-mapped single-cycle-fill cache to N ways with LRU replacement. Fills and write-throughs use a req/ack memory handshake, so memory latency is arbitrary. Formal property modules bind to it by hierarchical name, so internal array names are fixed (see Structure).

## Interface
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: word width; one word per line.
- `SETS`, 64: number of sets, power of two; `IDX_W = $clog2(SETS)`.
- `WAYS`, 2: associativity, power of two, 1..8.
- `TAG_W`, 6: tag width. Tag is `address[IDX_W+TAG_W-1:IDX_W]`; higher address bits are ignored for matching.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on `req_valid & req_ready`.
- `mode` in 1: 1 = write, 0 = read; sampled at acceptance.
- `address` in ADDR_W: request address.
- `data` in DATA_W: write data.
- `out` out DATA_W: read data; holds its last value between reads.
- `out_valid` out 1: one-cycle pulse when `out` is updated.
- `mem_rd_req` out 1 / `mem_rd_addr` out ADDR_W: fill request.
- `mem_rd_ack` in 1 / `mem_rd_data` in DATA_W: fill response.
- `mem_wr_req` out 1 / `mem_wr_addr` out ADDR_W / `mem_wr_data` out DATA_W: write-through request.
- `mem_wr_ack` in 1: write-through complete.
- `hit_count` out 32 / `miss_count` out 32: present only with `CACHE_STATS_EN`.

## Operation
- States: IDLE, FILL, WRITE.
- Lookup happens at acceptance. A hit means some way in set `index` has `valid_array=1` and `tag_array==tag`.
- **Read hit:** `out <= cache[index][way]`. Stay in IDLE. The hit way becomes MRU.
- **Read miss:** go to FILL, latching the address.
  - Drive `mem_rd_req=1` and `mem_rd_addr` until `mem_rd_ack` is sampled high.
  - On ack, write the victim way: data `<= mem_rd_data`, valid `<= 1`, tag `<=` latched tag. Also `out <= mem_rd_data`; the victim way becomes MRU.
  - Return to IDLE.
- **Victim selection:** the lowest-numbered invalid way; otherwise the LRU way.
- **Write hit:** update the hit way's data at acceptance; the way becomes MRU.
- **Write miss:** cache, valid, tag and LRU state are unchanged.
- **All writes:** go to WRITE. Hold `mem_wr_req=1`, `mem_wr_addr`, `mem_wr_data` until `mem_wr_ack`, then return to IDLE. `out` is unchanged.
- **LRU state:** per-set, per-way age counters of `$clog2(WAYS)` bits. The accessed way's age goes to 0; ages below its old age increment. For `WAYS=1` the LRU logic is elided.
- **Stray acks:** `mem_rd_ack` outside FILL and `mem_wr_ack` outside WRITE are ignored. `mem_*_data` is don't-care when not acked.
- **Same-set back-to-back requests:** the second request observes the first's array update. Arrays are written on the accepting/ack edge and read combinationally at the next acceptance.

## Timing
- **Reset values** (async, immediate): state IDLE; all `cache`, `valid_array`, `tag_array` and LRU ages 0; `out`=0; `out_valid`=0; `mem_rd_req`=`mem_wr_req`=0; `mem_*_addr`/`mem_wr_data`=0; counters 0.
- `req_ready` is combinational from state; it is 1 during the first cycle after reset release.
- **Read hit:** `out`/`out_valid` are valid the cycle after acceptance. `req_ready` stays high, allowing one request per cycle.
- **Read miss:** `mem_rd_req` rises the cycle after acceptance. `out`/`out_valid` are valid the cycle after the ack edge, which is also when `req_ready` rises. Minimum miss latency is 2 cycles when the ack arrives in the first request cycle.
- **Write:** `mem_wr_req` rises the cycle after acceptance. `req_ready` returns the cycle after the ack edge.
- **Reset mid-FILL/WRITE:** the outstanding request drops at once. No array update from the abandoned transaction is kept; reset clears everything.

## Configuration
- `CACHE_STATS_EN` defined: `hit_count` and `miss_count` ports exist.
  - Each accepted request increments exactly one counter, read or write, at acceptance.
  - Counters saturate at `32'hFFFF_FFFF`.
- `CACHE_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `cache_pkg` holds:
  - the `cache_state_e` enum (IDLE, FILL, WRITE);
  - typedef `cache_mode_e` (READ=0, WRITE=1);
  - helper functions for index/tag extraction.
- Sub-module `cache_lru` holds per-set age storage. Its inputs are set index, way, and update strobe; its outputs are the LRU way and the first-invalid selection.
- Internal arrays are named `cache`, `valid_array`, `tag_array`, with signals `index` and `tag`, for bound properties.

## Test plan
All scenarios use SETS=64, WAYS=2, TAG_W=6.
1. **Reset:** pulse `rst`=0 for 3 cycles, then release. All outputs are 0 and `req_ready`=1 the first cycle after release.
2. **Read miss then hit:** read `0x45` (index 5, tag 1). `mem_rd_req` and `mem_rd_addr=0x45` appear the next cycle. Ack with `0xDEADBEEF` after 3 cycles → `out=0xDEADBEEF` with an `out_valid` pulse. Reread `0x45` → `out_valid` the next cycle, no `mem_rd_req`.
3. **LRU eviction:** read `0x45`, `0x85`, `0xC5` (index 5, tags 1/2/3). The third read evicts tag 1. Reread `0x85` → hit; reread `0x45` → miss.
4. **Write hit/miss:** after filling `0x45`, write `0x12345678` → `mem_wr_req` with that data; reading `0x45` then hits with `0x12345678`. Write `0x105` (miss) → memory write only; reading `0x105` then misses.
5. **Reset mid-fill:** assert `rst` two cycles into FILL → `mem_rd_req` drops the same cycle. After release, reading the same address misses.
6. **Stats (`CACHE_STATS_EN`):** after scenario 2, `hit_count=1` and `miss_count=1`. Preloading a counter to `0xFFFF_FFFF` and hitting leaves it at `0xFFFF_FFFF`.
